// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues one request at a time to an external MUL_LAT-cycle multiplier and returns the product.
// Optional build macro MUL_ZERO_BYPASS_EN answers requests with a zero low-half operand immediately with 0.

module mul_issue_ctrl #(
    parameter int MUL_LAT = 9,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_x,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mul_rst,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_x,
    input  logic [31:0]      mul_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int               CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mul_a_q, mul_a_d;
    logic [31:0]      mul_x_q, mul_x_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             mul_rst_q, mul_rst_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic             req_ready_s;
    logic             accept_s;
    logic             zero_op_s;

    // Ready follows the consumer in DONE so a new request can overlap the response handshake.
    always_comb begin
        req_ready_s = 1'b0;
        if (state_q == IDLE) begin
            req_ready_s = 1'b1;
        end else if (state_q == DONE) begin
            req_ready_s = rsp_ready;
        end else begin
            req_ready_s = 1'b0;
        end
    end

    assign accept_s = req_valid && req_ready_s;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op_s = (req_a[15:0] == 16'h0000) || (req_x[15:0] == 16'h0000);
`else
    assign zero_op_s = 1'b0;
`endif

    // Next-state, counter, operand and response computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_x_d      = mul_x_q;
        tag_d        = tag_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = zero_op_s ? DONE : CLR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLR: begin
                cnt_d   = CNT_LOAD;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == CNT_ZERO) begin
                    rsp_result_d = mul_result;
                    rsp_tag_d    = tag_q;
                    state_d      = DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = RUN;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_d = zero_op_s ? DONE : CLR;
                end else if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operands are only captured on acceptance and otherwise held for the multiplier.
        if (accept_s) begin
            mul_a_d = req_a;
            mul_x_d = req_x;
            tag_d   = req_tag;
            if (zero_op_s) begin
                rsp_result_d = 32'h0000_0000;
                rsp_tag_d    = req_tag;
            end else begin
                rsp_tag_d = rsp_tag_d;
            end
        end else begin
            tag_d = tag_d;
        end

        mul_rst_d   = (state_d != RUN);
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            mul_a_q      <= 32'h0000_0000;
            mul_x_q      <= 32'h0000_0000;
            tag_q        <= {TAG_W{1'b0}};
            rsp_result_q <= 32'h0000_0000;
            rsp_tag_q    <= {TAG_W{1'b0}};
            mul_rst_q    <= 1'b1;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_x_q      <= mul_x_d;
            tag_q        <= tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            mul_rst_q    <= mul_rst_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign mul_rst    = mul_rst_q;
    assign mul_a      = mul_a_q;
    assign mul_x      = mul_x_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural 16x16 signed multiplier that
// only presents a valid product in its MUL_LAT-th run cycle.

module tb_mul_issue_ctrl;

    localparam int MUL_LAT = 9;
    localparam int TAG_W   = 5;
`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_x;
    logic [TAG_W-1:0] req_tag;
    logic             mul_rst;
    logic [31:0]      mul_a;
    logic [31:0]      mul_x;
    logic [31:0]      mul_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    mul_issue_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_x      (req_x),
        .req_tag    (req_tag),
        .mul_rst    (mul_rst),
        .mul_a      (mul_a),
        .mul_x      (mul_x),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: garbage except in exactly the MUL_LAT-th cycle out of reset.
    int run_cnt = 0;
    always @(posedge clk) begin
        if (mul_rst) run_cnt <= 0;
        else         run_cnt <= run_cnt + 1;
    end

    function automatic logic [31:0] smul16(input logic [31:0] a, input logic [31:0] x);
        logic signed [31:0] sa;
        logic signed [31:0] sx;
        sa = {{16{a[15]}}, a[15:0]};
        sx = {{16{x[15]}}, x[15:0]};
        return sa * sx;
    endfunction

    assign mul_result = (!mul_rst && run_cnt == MUL_LAT - 1) ? smul16(mul_a, mul_x) : 32'hBAD0_BAD0;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               acc;
        int               lat;
    } exp_t;

    exp_t exp_q[$];
    bit   seen = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Called at a negedge; returns just after the accepting posedge with req_valid dropped.
    task automatic send(input logic [31:0] a, input logic [31:0] x, input logic [TAG_W-1:0] tag,
                        input logic [31:0] exp_res, output int acc_cyc);
        bit   acc;
        exp_t e;
        acc_cyc   = -1;
        req_a     = a;
        req_x     = x;
        req_tag   = tag;
        req_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            acc = req_ready;
            if (acc) begin
                e.res = exp_res;
                e.tag = tag;
                e.acc = cyc;
                e.lat = (BYP && (a[15:0] == 16'h0 || x[15:0] == 16'h0)) ? 1 : MUL_LAT + 2;
                acc_cyc = cyc;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        fail_now("accept_timeout");
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
            #3;
        end
        fail_now("drain_timeout");
    endtask

    // Monitor: latency on first valid, result/tag on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 with no pending request (cycle %0d)", cyc);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                    end
                    if (rsp_ready) begin
                        chk("rsp_result", rsp_result, exp_q[0].res);
                        chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int t1;
        int t2;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_a     = 32'h0;
        req_x     = 32'h0;
        req_tag   = '0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mul_rst", 32'(mul_rst), 32'd1);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_x", mul_x, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // First request offered in the same cycle reset deasserts.
        reset = 1'b1;
        send(32'd3, 32'd5, 5'd3, 32'd15, t1);
        chk("mul_a_cap", mul_a, 32'd3);
        chk("mul_x_cap", mul_x, 32'd5);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mul_rst_c%0d", i), 32'(mul_rst), (i >= 2 && i <= 10) ? 32'd0 : 32'd1);
        end
        wait_drain();

        @(negedge clk);
        send(32'h0000_FFFE, 32'd7, 5'd7, 32'hFFFF_FFF2, t1);
        wait_drain();
        @(negedge clk);
        send(32'hABCD_0002, 32'd3, 5'd9, 32'd6, t1);
        wait_drain();
        @(negedge clk);
        send(32'h0000_8000, 32'h0000_8000, 5'd31, 32'h4000_0000, t1);
        wait_drain();

        // Backpressure for 5 cycles in DONE.
        @(negedge clk);
        rsp_ready = 1'b0;
        send(32'h0000_1234, 32'h0000_0010, 5'd12, 32'h0001_2340, t1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #3;
            if (rsp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", rsp_result, 32'h0001_2340);
            chk("bp_tag", 32'(rsp_tag), 32'd12);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        wait_drain();

        // Back-to-back: second request held valid through CLR/RUN, taken in the handshake cycle.
        @(negedge clk);
        send(32'd100, 32'd200, 5'd1, 32'd20000, t1);
        @(negedge clk);
        send(32'h0000_FFFF, 32'h0000_FFFF, 5'd2, 32'd1, t2);
        chk("b2b_accept_gap", 32'(t2 - t1), 32'(MUL_LAT + 2));
        wait_drain();

        // Zero operand: bypass latency 1 when enabled, else full path.
        @(negedge clk);
        send(32'd0, 32'd9, 5'd4, 32'd0, t1);
        wait_drain();

        // Reset pulse in the middle of RUN.
        @(negedge clk);
        send(32'd3, 32'd5, 5'd10, 32'd15, t1);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_mul_rst", 32'(mul_rst), 32'd1);
        chk("mid_mul_a", mul_a, 32'd0);
        chk("mid_rsp_result", rsp_result, 32'd0);
        chk("mid_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        send(32'h0000_7FFF, 32'h0000_7FFF, 5'd21, 32'h3FFF_0001, t1);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 9: number of RUN cycles the downstream Booth multiplier needs after its reset deasserts.
REQ-002 SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: a request is offered.
REQ-006 SHALL have port req_ready, output, 1: the block accepts a request this cycle.
REQ-007 SHALL have ports req_a and req_x, input, 32 each: multiplicand and multiplier operands.
REQ-008 SHALL have port req_tag, input, TAG_W: request tag.
REQ-009 SHALL have port mul_rst, output, 1: active-high synchronous clear to the multiplier.
REQ-010 SHALL have ports mul_a and mul_x, output, 32 each: operands driven to the multiplier.
REQ-011 SHALL have port mul_result, input, 32: product from the multiplier.
REQ-012 SHALL have port rsp_valid, output, 1: response valid.
REQ-013 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-014 SHALL have port rsp_result, output, 32: the product.
REQ-015 SHALL have port rsp_tag, output, TAG_W: tag of the response.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, CLR, RUN and DONE.
REQ-018 In IDLE, req_ready SHALL be 1; on req_valid&&req_ready, req_a, req_x and req_tag SHALL be registered into mul_a, mul_x and the tag register, and the next state SHALL be CLR.
REQ-019 mul_rst SHALL be 1 in IDLE, CLR and DONE, and 0 only in RUN.
REQ-020 In CLR, the down-counter SHALL load MUL_LAT-1, and the next state SHALL be RUN after exactly one cycle.
REQ-021 In RUN, the counter SHALL decrement each cycle; in the cycle it equals 0, mul_result SHALL be captured into rsp_result and the next state SHALL be DONE.
REQ-022 mul_a and mul_x SHALL hold stable from the cycle after acceptance until the next acceptance.
REQ-023 Latency: with acceptance in cycle T, rsp_valid SHALL be 1 from cycle T+2+MUL_LAT (T+11 at default).
REQ-024 In DONE, rsp_valid SHALL be 1, and rsp_result and rsp_tag SHALL hold until rsp_valid&&rsp_ready.
REQ-025 In DONE, req_ready SHALL equal rsp_ready; a simultaneous response handshake and new request SHALL go to CLR with the new operands, with no bubble cycle.
REQ-026 On a response handshake with no new request, the next state SHALL be IDLE and rsp_valid SHALL drop to 0.
REQ-027 req_ready SHALL be 0 in CLR and RUN; req_valid in those states SHALL be ignored.
REQ-028 The block SHALL perform no arithmetic on operands; the product width is 32 bits, taken unmodified from mul_result.

Reset
REQ-029 While reset=0, the block SHALL asynchronously clear to: state IDLE, counter 0, mul_a=0, mul_x=0, mul_rst=1, rsp_valid=0, rsp_result=0, rsp_tag=0, busy=0.
REQ-030 A reset assertion in CLR, RUN or DONE SHALL abort the operation and discard any pending response.
REQ-031 After reset deasserts, the block SHALL accept a request in the first clock edge.

Configuration
REQ-032 Macro MUL_ZERO_BYPASS_EN: when it is defined and req_a[15:0]==0 or req_x[15:0]==0 at acceptance, the block SHALL go directly to DONE with rsp_result=0 and rsp_valid=1 at T+1, and mul_rst SHALL stay 1.
REQ-033 When MUL_ZERO_BYPASS_EN is not defined, every request SHALL take the full CLR/RUN path of REQ-023.

Verification
REQ-034 Single multiply: a=3, x=5, rsp_ready=1, accepted at T -> rsp_valid at T+11, rsp_result=15, tag echoed, mul_rst low for cycles T+2..T+10.
REQ-035 Signed operands: a=0x0000FFFE, x=7 -> rsp_result=0xFFFFFFF2.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_result and rsp_tag stable; req_ready=0 throughout.
REQ-037 Back-to-back: second request offered in the handshake cycle -> accepted in that cycle; second rsp_valid exactly 11 cycles later.
REQ-038 Reset mid-RUN: reset pulsed low at T+5 -> all outputs at reset values immediately, no rsp_valid afterward; next request completes normally.
REQ-039 Bypass: a=0, x=9 -> with MUL_ZERO_BYPASS_EN, rsp_result=0 at T+1; without it, rsp_result=0 at T+11.
